// File: rtl/alu_pkg.sv
// Shared opcode encodings and internal shifter selects for the registered ALU.
// Imported by alu_shifter and alu_reg32.
package alu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ADC   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SBB   = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND   = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR    = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_NOT   = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_NEG   = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_INC   = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_DEC   = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_SHL   = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_SHR   = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_SAR   = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_ROL   = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_ROR   = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_CMP   = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_PASSA = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_PASSB = 5'b10011;

  typedef enum logic [2:0] {
    SH_PASS,
    SH_SHL,
    SH_SHR,
    SH_SAR,
    SH_ROL,
    SH_ROR
  } shift_op_e;

  // Maps an ALU opcode onto the shifter select; non-shift opcodes give SH_PASS.
  function automatic shift_op_e shift_op_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SHL:  return SH_SHL;
      OP_SHR:  return SH_SHR;
      OP_SAR:  return SH_SAR;
      OP_ROL:  return SH_ROL;
      OP_ROR:  return SH_ROR;
      default: return SH_PASS;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator: result plus the shift-out carry.
// An amount of zero passes the value through with carry cleared.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  shift_op_e          op,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHW-1:0]     amount,
  output logic [WIDTH-1:0]   result,
  output logic               carry
);

  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] dbl;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    ext    = '0;
    dbl    = '0;
    result = value;
    carry  = 1'b0;
    case (op)
      SH_SHL: begin
        // The extra top bit catches the last bit shifted out (zero when amount is 0).
        ext    = {1'b0, value} << amount;
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      SH_SHR: begin
        ext    = {value, 1'b0} >> amount;
        result = ext[WIDTH:1];
        carry  = ext[0];
      end
      SH_SAR: begin
        ext    = $signed({value, 1'b0}) >>> amount;
        result = ext[WIDTH:1];
        carry  = ext[0];
      end
      SH_ROL: begin
        dbl    = {value, value} << amount;
        result = dbl[2*WIDTH-1:WIDTH];
        carry  = (amount != '0) && dbl[WIDTH];
      end
      SH_ROR: begin
        dbl    = {value, value} >> amount;
        result = dbl[WIDTH-1:0];
        carry  = (amount != '0) && dbl[WIDTH-1];
      end
      default: begin
        result = value;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_reg32.sv
// Registered 32-bit integer ALU with C/S/O/Z flags and one-cycle latency.
// Adder/subtractor, logic ops and the output registers live here; shifts use alu_shifter.
module alu_reg32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    operando_a,
  input  logic [WIDTH-1:0]    operando_b,
  output logic [WIDTH-1:0]    resultado,
  output logic                C,
  output logic                S,
  output logic                O,
  output logic                Z
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  // Shared adder/subtractor operands
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             add_sub;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_ovf;

  logic [WIDTH-1:0] sh_result;
  logic             sh_carry;

  logic [WIDTH-1:0] res;
  logic             wr_flags;
  logic             wr_result;
  logic [WIDTH-1:0] r_nxt;
  logic             c_nxt;
  logic             s_nxt;
  logic             o_nxt;
  logic             z_nxt;

  always_comb begin
    add_x   = operando_a;
    add_y   = operando_b;
    add_cin = 1'b0;
    add_sub = 1'b0;
    case (opcode)
      OP_ADC: add_cin = C;
      OP_SUB, OP_CMP: add_sub = 1'b1;
      OP_SBB: begin
        add_sub = 1'b1;
        add_cin = C;
      end
      OP_INC: add_y = WIDTH'(1);
      OP_DEC: begin
        add_sub = 1'b1;
        add_y   = WIDTH'(1);
      end
      OP_NEG: begin
        add_sub = 1'b1;
        add_x   = '0;
        add_y   = operando_a;
      end
      default: ;
    endcase
  end

  // In subtract mode bit WIDTH of the wrapped difference is the borrow.
  assign add_ext = add_sub
                 ? ({1'b0, add_x} - {1'b0, add_y} - (WIDTH + 1)'(add_cin))
                 : ({1'b0, add_x} + {1'b0, add_y} + (WIDTH + 1)'(add_cin));
  assign add_sum   = add_ext[WIDTH-1:0];
  assign add_carry = add_ext[WIDTH];
  assign add_ovf   = add_sub
                   ? ((add_x[MSB] != add_y[MSB]) && (add_sum[MSB] != add_x[MSB]))
                   : ((add_x[MSB] == add_y[MSB]) && (add_sum[MSB] != add_x[MSB]));

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .op     (shift_op_of(opcode)),
    .value  (operando_a),
    .amount (operando_b[SHW-1:0]),
    .result (sh_result),
    .carry  (sh_carry)
  );

  always_comb begin
    res       = operando_a;
    wr_flags  = 1'b1;
    wr_result = 1'b1;
    r_nxt     = resultado;
    c_nxt     = C;
    s_nxt     = S;
    o_nxt     = O;
    z_nxt     = Z;
    case (opcode)
      OP_ADD, OP_ADC, OP_INC,
      OP_SUB, OP_SBB, OP_DEC, OP_NEG: begin
        res   = add_sum;
        c_nxt = add_carry;
        o_nxt = add_ovf;
      end
      OP_CMP: begin
        res       = add_sum;
        c_nxt     = add_carry;
        o_nxt     = add_ovf;
        wr_result = 1'b0;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PASSA, OP_PASSB: begin
        case (opcode)
          OP_AND:   res = operando_a & operando_b;
          OP_OR:    res = operando_a | operando_b;
          OP_XOR:   res = operando_a ^ operando_b;
          OP_NOT:   res = ~operando_a;
          OP_PASSB: res = operando_b;
          default:  res = operando_a;
        endcase
        c_nxt = 1'b0;
        o_nxt = 1'b0;
      end
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        res   = sh_result;
        c_nxt = sh_carry;
        o_nxt = 1'b0;
      end
      default: begin
        // NOP and the unused encodings hold everything
        wr_flags  = 1'b0;
        wr_result = 1'b0;
      end
    endcase
    if (wr_flags) begin
      s_nxt = res[MSB];
      z_nxt = (res == '0);
    end
    if (wr_result) begin
      r_nxt = res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      resultado <= '0;
      C         <= 1'b0;
      S         <= 1'b0;
      O         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      resultado <= r_nxt;
      C         <= c_nxt;
      S         <= s_nxt;
      O         <= o_nxt;
      Z         <= z_nxt;
    end
  end

endmodule

// File: tb/tb_alu_reg32.sv
// Directed bench for alu_reg32: expected results are queued when an op is driven
// and popped/compared one cycle later when the registered outputs appear.
module tb_alu_reg32;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] resultado;
  logic        c_flag;
  logic        s_flag;
  logic        o_flag;
  logic        z_flag;

  always #5 clk = ~clk;

  alu_reg32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .operando_a (a),
    .operando_b (b),
    .resultado  (resultado),
    .C          (c_flag),
    .S          (s_flag),
    .O          (o_flag),
    .Z          (z_flag)
  );

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic [3:0]  csoz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] er, input logic [3:0] csoz);
    check({tag, ".R"}, resultado, er);
    check({tag, ".C"}, 32'(c_flag), 32'(csoz[3]));
    check({tag, ".S"}, 32'(s_flag), 32'(csoz[2]));
    check({tag, ".O"}, 32'(o_flag), 32'(csoz[1]));
    check({tag, ".Z"}, 32'(z_flag), 32'(csoz[0]));
  endtask

  task automatic retire();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check_outputs(e.tag, e.r, e.csoz);
    end
  endtask

  // Drive one op at the falling edge, queue its expectation, compare after the next rising edge.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] er, input logic [3:0] csoz);
    exp_t e;
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
    e.tag  = tag;
    e.r    = er;
    e.csoz = csoz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    opcode = OP_NOP;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // csoz = {C, S, O, Z}
    issue("nop0",  OP_NOP,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000);
    issue("nop1",  OP_NOP,   32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 4'b0000);

    issue("add0",  OP_ADD,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1011);
    issue("adc0",  OP_ADC,   32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 4'b0000);
    issue("add1",  OP_ADD,   32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 4'b1100);
    issue("add2",  OP_ADD,   32'hFFFF_0000, 32'h0FFF_1111, 32'h0FFE_1111, 4'b1000);
    issue("add3",  OP_ADD,   32'h7FFF_0000, 32'h7FFF_1111, 32'hFFFE_1111, 4'b0110);
    issue("add4",  OP_ADD,   32'h7FFF_0000, 32'h0FFF_1111, 32'h8FFE_1111, 4'b0110);

    issue("not0",  OP_NOT,   32'hACED_CAFE, 32'hxxxx_xxxx, 32'h5312_3501, 4'b0000);
    issue("not1",  OP_NOT,   32'h5312_3501, 32'hxxxx_xxxx, 32'hACED_CAFE, 4'b0100);

    issue("sub0",  OP_SUB,   32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b1100);
    issue("sbb0",  OP_SBB,   32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 4'b0000);
    issue("cmp0",  OP_CMP,   32'h8000_0000, 32'h0000_0001, 32'h0000_0002, 4'b0010);
    issue("cmp1",  OP_CMP,   32'h0000_0005, 32'h0000_0005, 32'h0000_0002, 4'b0001);

    issue("and0",  OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100);
    issue("or0",   OP_OR,    32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000);
    issue("xor0",  OP_XOR,   32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b0001);

    issue("neg0",  OP_NEG,   32'h8000_0000, 32'hxxxx_xxxx, 32'h8000_0000, 4'b1110);
    issue("neg1",  OP_NEG,   32'h0000_0000, 32'hxxxx_xxxx, 32'h0000_0000, 4'b0001);
    issue("neg2",  OP_NEG,   32'h0000_0001, 32'hxxxx_xxxx, 32'hFFFF_FFFF, 4'b1100);
    issue("inc0",  OP_INC,   32'h7FFF_FFFF, 32'hxxxx_xxxx, 32'h8000_0000, 4'b0110);
    issue("inc1",  OP_INC,   32'hFFFF_FFFF, 32'hxxxx_xxxx, 32'h0000_0000, 4'b1001);
    issue("dec0",  OP_DEC,   32'h0000_0000, 32'hxxxx_xxxx, 32'hFFFF_FFFF, 4'b1100);
    issue("dec1",  OP_DEC,   32'h8000_0000, 32'hxxxx_xxxx, 32'h7FFF_FFFF, 4'b0010);

    issue("shl1",  OP_SHL,   32'h8000_0001, 32'd1,         32'h0000_0002, 4'b1000);
    issue("sar4",  OP_SAR,   32'h8000_0001, 32'd4,         32'hF800_0000, 4'b0100);
    issue("ror1",  OP_ROR,   32'h8000_0001, 32'd1,         32'hC000_0000, 4'b1100);
    issue("shl0",  OP_SHL,   32'h8000_0001, 32'd0,         32'h8000_0001, 4'b0100);
    issue("shr1",  OP_SHR,   32'h8000_0001, 32'd1,         32'h4000_0000, 4'b1000);
    issue("rol1",  OP_ROL,   32'h8000_0001, 32'd1,         32'h0000_0003, 4'b1000);
    issue("shl31", OP_SHL,   32'h8000_0001, 32'd31,        32'h8000_0000, 4'b0100);
    issue("ror32", OP_ROR,   32'h8000_0001, 32'd32,        32'h8000_0001, 4'b0100);

    issue("passb", OP_PASSB, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0001);
    issue("passa", OP_PASSA, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 4'b0100);
    issue("ill0",  5'b10101, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0100);
    issue("ill1",  5'b11111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0100);

    // Asynchronous reset in the middle of an ADD stream
    issue("add5",  OP_ADD,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1001);
    @(negedge clk);
    opcode = OP_ADD;
    a      = 32'h0000_0005;
    b      = 32'h0000_0006;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("rst_async", 32'h0, 4'b0000);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    issue("adc1",  OP_ADC,   32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
